conv_patch_scheduler: RTL and testbench
=======================================

Name: conv_patch_scheduler

Overview:
- Frame-level sequencer for the patch convolution datapath (multiplier array feeding per-pixel 18-input adder trees).
- Loads the kernel pair once per frame, then walks the feature map patch by patch in raster order. For each patch it requests data from the patch buffer and drives the datapath's data-valid.
- Tracks in-flight patches through the fixed datapath latency and tags each result with its patch coordinates.
- Throttles issue with a credit counter so the downstream result FIFO can never overflow.

Parameters:
- PATCH_ROWS, 4, patches per frame vertically (>=1)
- PATCH_COLS, 4, patches per frame horizontally (>=1)
- PIPE_LATENCY, 6, cycles from core_vld to the matching result at the datapath output (>=1)
- OUT_CREDITS, 8, downstream result FIFO depth; maximum patches issued but not yet retired
- COORD_W, 8, width of the row and column coordinate fields

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begin a frame (ignored unless IDLE)
- abort  in  1  pulse; synchronous abort of the current frame
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when the frame's last result leaves
- kload_req  out  1  kernel load request
- kload_ack  in  1  kernel registers loaded
- rd_req  out  1  patch read request
- rd_row  out  COORD_W  requested patch row
- rd_col  out  COORD_W  requested patch column
- rd_ack  in  1  patch accepted; data valid next cycle
- core_vld  out  1  datapath data-valid (the core's infms_data_vld)
- out_vld  out  1  datapath result valid
- out_row  out  COORD_W  result patch row
- out_col  out  COORD_W  result patch column
- out_last  out  1  result is the frame's final patch
- credit_ret  in  1  pulse; downstream freed one FIFO entry

Behaviour:
- Reset: state IDLE. All outputs 0, row/col counters 0, token pipe cleared, credits = OUT_CREDITS.
- IDLE:
  - start -> KLOAD, with kload_req registered high.
- KLOAD:
  - kload_req held high until kload_ack is sampled.
  - kload_ack -> RUN; kload_req drops the same edge.
- RUN:
  - rd_req = 1 whenever credits > 0 and patches remain; otherwise rd_req = 0.
  - rd_row and rd_col must hold stable while rd_req is high and rd_ack is low.
  - On rd_req & rd_ack: credits decrement; column advances; at PATCH_COLS-1 column wraps to 0 and row increments.
  - After the last patch (PATCH_ROWS-1, PATCH_COLS-1) is accepted -> DRAIN.
- Issue-to-core timing: core_vld is registered and equals (rd_req & rd_ack) delayed 1 cycle.
- Token pipe:
  - Each core_vld pushes a token {row, col, last} into a PIPE_LATENCY-deep shift register.
  - out_vld, out_row, out_col and out_last are the pipe head, registered.
  - So out_vld rises exactly PIPE_LATENCY cycles after core_vld.
  - Back-to-back issue gives back-to-back results.
- DRAIN:
  - No new requests.
  - When out_vld & out_last fires -> IDLE.
  - done pulses in that same cycle.
- Credits:
  - Saturate at 0..OUT_CREDITS.
  - Issue and credit_ret in the same cycle leave the count unchanged.
  - credit_ret at OUT_CREDITS is ignored (no wrap).
  - Credits persist across frames; they are not reset at frame start.
- abort (any non-IDLE state):
  - Next state IDLE.
  - rd_req and kload_req drop next edge.
  - Counters are zeroed and the token pipe is flushed, so no out_vld after abort.
  - Credits are kept.
  - done is not pulsed.
- Simultaneous events:
  - abort has priority over rd_ack, kload_ack and start.
  - start while busy is ignored.
- PATCH_ROWS = PATCH_COLS = 1: the single patch is both first and last; the FSM goes RUN -> DRAIN on its acceptance.
- rst mid-frame: immediate return to the reset state (asynchronous).

Optional Feature:
- Macro: CONV_SCHED_PERF_EN.
- Defined:
  - Adds output ports stall_cycles[31:0] and frame_cycles[31:0], both cleared on start.
  - frame_cycles counts every cycle while busy.
  - stall_cycles counts RUN cycles with patches remaining and either credits = 0 or (rd_req & !rd_ack).
  - Both counters saturate at all-ones and hold their value in IDLE.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Nominal frame: PATCH_ROWS=2, PATCH_COLS=3, rd_ack tied 1, credit_ret pulsed for every out_vld -> 6 core_vld pulses; results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); each out_vld 6 cycles after its core_vld; out_last and done only on (1,2).
- Credit stall: OUT_CREDITS=8, 16 patches, credit_ret held 0 -> exactly 8 issues, then rd_req stays low; one credit_ret pulse -> exactly one more issue.
- Read backpressure: rd_ack low for 5 cycles at patch (1,2) -> rd_row/rd_col hold 1/2 and no core_vld during the stall; the sequence resumes without gaps or duplicates.
- Simultaneous issue and credit_ret with credits = 3 -> credits stay 3; credit_ret at 8 -> credits stay 8.
- Abort: abort while 3 tokens are in flight in RUN -> busy low next cycle, no out_vld afterwards, no done; a new start runs a full frame with results from (0,0).
- Async reset asserted in DRAIN between clock edges -> all outputs 0 immediately; with CONV_SCHED_PERF_EN, frame_cycles=0.

Source files
------------

// File: rtl/conv_patch_scheduler.sv
// Frame sequencer for the patch convolution datapath: kernel load, raster patch issue,
// latency-matched result tagging and credit-based throttling. Optional counters: CONV_SCHED_PERF_EN.
module conv_patch_scheduler #(
   parameter int unsigned PATCH_ROWS   = 4,
   parameter int unsigned PATCH_COLS   = 4,
   parameter int unsigned PIPE_LATENCY = 6,
   parameter int unsigned OUT_CREDITS  = 8,
   parameter int unsigned COORD_W      = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               kload_req,
   input  logic               kload_ack,
   output logic               rd_req,
   output logic [COORD_W-1:0] rd_row,
   output logic [COORD_W-1:0] rd_col,
   input  logic               rd_ack,
   output logic               core_vld,
   output logic               out_vld,
   output logic [COORD_W-1:0] out_row,
   output logic [COORD_W-1:0] out_col,
   output logic               out_last,
   input  logic               credit_ret
`ifdef CONV_SCHED_PERF_EN
   ,
   output logic [31:0]        stall_cycles,
   output logic [31:0]        frame_cycles
`endif
);

   localparam int unsigned        CRED_W   = $clog2(OUT_CREDITS + 1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(PATCH_ROWS - 1);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(PATCH_COLS - 1);
   localparam logic [CRED_W-1:0]  CRED_MAX = CRED_W'(OUT_CREDITS);

   typedef enum logic [1:0] {S_IDLE, S_KLOAD, S_RUN, S_DRAIN} state_e;

   state_e                   state_q, state_d;
   logic [COORD_W-1:0]       row_q, row_d, col_q, col_d;
   logic [CRED_W-1:0]        cred_q, cred_d;
   logic                     kload_req_q, kload_req_d;
   logic                     rd_req_q, rd_req_d;
   logic                     core_vld_q, core_vld_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [COORD_W-1:0]       iss_row_q, iss_row_d, iss_col_q, iss_col_d;
   logic                     iss_last_q, iss_last_d;
   logic [PIPE_LATENCY-1:0]  pv_q, pv_d, pl_q, pl_d;
   logic [COORD_W-1:0]       pr_q [PIPE_LATENCY];
   logic [COORD_W-1:0]       pr_d [PIPE_LATENCY];
   logic [COORD_W-1:0]       pc_q [PIPE_LATENCY];
   logic [COORD_W-1:0]       pc_d [PIPE_LATENCY];

   logic issue, is_last, start_ok, aborting;

   assign aborting = abort && (state_q != S_IDLE);
   assign start_ok = (state_q == S_IDLE) && start && !abort;
   // rd_req is only ever high in RUN, so this is the accepted-patch strobe
   assign issue    = rd_req_q && rd_ack && !abort;
   assign is_last  = (row_q == LAST_ROW) && (col_q == LAST_COL);

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      cred_d      = cred_q;
      kload_req_d = 1'b0;
      core_vld_d  = issue;
      iss_row_d   = row_q;
      iss_col_d   = col_q;
      iss_last_d  = is_last;
      pv_d        = '0;
      pl_d        = '0;
      pv_d[0]     = core_vld_q;
      pl_d[0]     = iss_last_q;
      pr_d[0]     = iss_row_q;
      pc_d[0]     = iss_col_q;
      for (int k = 1; k < PIPE_LATENCY; k++) begin
         pv_d[k] = pv_q[k-1];
         pl_d[k] = pl_q[k-1];
         pr_d[k] = pr_q[k-1];
         pc_d[k] = pc_q[k-1];
      end

      // simultaneous issue and return cancel out; returns beyond the FIFO depth are dropped
      if (issue && !credit_ret) begin
         cred_d = cred_q - CRED_W'(1);
      end else if (!issue && credit_ret && (cred_q != CRED_MAX)) begin
         cred_d = cred_q + CRED_W'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d     = S_KLOAD;
               kload_req_d = 1'b1;
            end
         end
         S_KLOAD: begin
            if (kload_ack) state_d = S_RUN;
            else           kload_req_d = 1'b1;
         end
         S_RUN: begin
            if (issue) begin
               if (is_last) begin
                  state_d = S_DRAIN;
                  row_d   = '0;
                  col_d   = '0;
               end else if (col_q == LAST_COL) begin
                  col_d = '0;
                  row_d = row_q + COORD_W'(1);
               end else begin
                  col_d = col_q + COORD_W'(1);
               end
            end
         end
         S_DRAIN: begin
            if (pv_q[PIPE_LATENCY-1] && pl_q[PIPE_LATENCY-1]) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (aborting) begin
         state_d     = S_IDLE;
         row_d       = '0;
         col_d       = '0;
         kload_req_d = 1'b0;
         core_vld_d  = 1'b0;
         pv_d        = '0;
      end

      rd_req_d = (state_d == S_RUN) && (cred_d != '0);
      busy_d   = (state_d != S_IDLE);
      done_d   = pv_d[PIPE_LATENCY-1] && pl_d[PIPE_LATENCY-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         row_q       <= '0;
         col_q       <= '0;
         cred_q      <= CRED_MAX;
         kload_req_q <= 1'b0;
         rd_req_q    <= 1'b0;
         core_vld_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         iss_row_q   <= '0;
         iss_col_q   <= '0;
         iss_last_q  <= 1'b0;
         pv_q        <= '0;
         pl_q        <= '0;
         for (int k = 0; k < PIPE_LATENCY; k++) begin
            pr_q[k] <= '0;
            pc_q[k] <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cred_q      <= cred_d;
         kload_req_q <= kload_req_d;
         rd_req_q    <= rd_req_d;
         core_vld_q  <= core_vld_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         iss_row_q   <= iss_row_d;
         iss_col_q   <= iss_col_d;
         iss_last_q  <= iss_last_d;
         pv_q        <= pv_d;
         pl_q        <= pl_d;
         for (int k = 0; k < PIPE_LATENCY; k++) begin
            pr_q[k] <= pr_d[k];
            pc_q[k] <= pc_d[k];
         end
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign kload_req = kload_req_q;
   assign rd_req    = rd_req_q;
   assign rd_row    = row_q;
   assign rd_col    = col_q;
   assign core_vld  = core_vld_q;
   assign out_vld   = pv_q[PIPE_LATENCY-1];
   assign out_last  = pl_q[PIPE_LATENCY-1];
   assign out_row   = pr_q[PIPE_LATENCY-1];
   assign out_col   = pc_q[PIPE_LATENCY-1];

`ifdef CONV_SCHED_PERF_EN
   logic [31:0] stall_q, stall_d, frame_q, frame_d;

   // saturating frame/stall counters, frozen while idle
   always_comb begin
      stall_d = stall_q;
      frame_d = frame_q;
      if (start_ok) begin
         stall_d = '0;
         frame_d = '0;
      end else begin
         if (busy_q && (frame_q != '1)) frame_d = frame_q + 32'd1;
         if ((state_q == S_RUN) && ((cred_q == '0) || (rd_req_q && !rd_ack)) &&
             (stall_q != '1)) stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
         frame_q <= '0;
      end else begin
         stall_q <= stall_d;
         frame_q <= frame_d;
      end
   end

   assign stall_cycles = stall_q;
   assign frame_cycles = frame_q;
`endif

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Directed bench for conv_patch_scheduler (4x4 patches, latency 6, 8 credits) with a result scoreboard.
module tb_conv_patch_scheduler;
   localparam int unsigned R = 4, C = 4, L = 6, CR = 8, W = 8;

   logic clk = 1'b0;
   logic rst, start, abort, kload_ack, rd_ack, credit_ret;
   logic busy, done, kload_req, rd_req, core_vld, out_vld, out_last;
   logic [W-1:0] rd_row, rd_col, out_row, out_col;
`ifdef CONV_SCHED_PERF_EN
   logic [31:0] stall_cycles, frame_cycles;
`endif

   always #5 clk = ~clk;

   conv_patch_scheduler #(
      .PATCH_ROWS(R), .PATCH_COLS(C), .PIPE_LATENCY(L), .OUT_CREDITS(CR), .COORD_W(W)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .kload_req(kload_req), .kload_ack(kload_ack), .rd_req(rd_req), .rd_row(rd_row),
      .rd_col(rd_col), .rd_ack(rd_ack), .core_vld(core_vld), .out_vld(out_vld),
      .out_row(out_row), .out_col(out_col), .out_last(out_last), .credit_ret(credit_ret)
`ifdef CONV_SCHED_PERF_EN
      , .stall_cycles(stall_cycles), .frame_cycles(frame_cycles)
`endif
   );

   typedef struct packed {
      logic [W-1:0] row;
      logic [W-1:0] col;
      logic         last;
      logic [31:0]  due;
   } tok_t;

   tok_t         sb[$];
   int           checks = 0, errors = 0, cyc = 0;
   int           m_row = 0, m_col = 0, n_iss = 0, n_out = 0, n_done = 0, n_busy = 0;
   bit           auto_ret = 1'b0;
   logic         req_s = 1'b0;
   logic [W-1:0] row_s = '0, col_s = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock: update the model from the handshake seen at this edge, then score outputs
   task automatic tick();
      tok_t t;
      logic acc, exp_done;
      @(posedge clk);
      #1;
      cyc++;
      acc      = req_s && rd_ack && !abort;
      exp_done = 1'b0;
      if (abort) begin
         sb.delete();
         m_row = 0;
         m_col = 0;
      end
      if (acc) begin
         chk("rd_row_at_accept", 32'(row_s), 32'(m_row));
         chk("rd_col_at_accept", 32'(col_s), 32'(m_col));
         t.row  = W'(m_row);
         t.col  = W'(m_col);
         t.last = (m_row == R - 1) && (m_col == C - 1);
         t.due  = 32'(cyc + L);
         sb.push_back(t);
         n_iss++;
         if (t.last) begin
            m_row = 0;
            m_col = 0;
         end else if (m_col == C - 1) begin
            m_col = 0;
            m_row++;
         end else begin
            m_col++;
         end
      end
      chk("core_vld", 32'(core_vld), 32'(acc));
      if (out_vld) begin
         if (sb.size() == 0) begin
            chk("out_vld_spurious", 32'(out_vld), 32'd0);
         end else begin
            t = sb.pop_front();
            chk("out_row", 32'(out_row), 32'(t.row));
            chk("out_col", 32'(out_col), 32'(t.col));
            chk("out_last", 32'(out_last), 32'(t.last));
            chk("out_latency", 32'(cyc), t.due);
            exp_done = t.last;
            n_out++;
         end
      end else if (sb.size() != 0 && sb[0].due <= 32'(cyc)) begin
         chk("out_vld_missing", 32'(out_vld), 32'd1);
      end
      chk("done", 32'(done), 32'(exp_done));
      if (done) n_done++;
      if (busy) n_busy++;
      credit_ret = auto_ret && out_vld;
      req_s = rd_req;
      row_s = rd_row;
      col_s = rd_col;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic wait_done(input int lim);
      int k = 0;
      while (!done && k < lim) begin
         tick();
         k++;
      end
      chk("done_seen", 32'(done), 32'd1);
   endtask

   task automatic kload_seq(input logic exp_req);
      n_busy = 0;
      start  = 1'b1;
      tick();
      start = 1'b0;
      chk("kload_req_set", 32'(kload_req), 32'd1);
      chk("busy_set", 32'(busy), 32'd1);
      tick();
      chk("kload_req_hold", 32'(kload_req), 32'd1);
      kload_ack = 1'b1;
      tick();
      kload_ack = 1'b0;
      chk("kload_req_drop", 32'(kload_req), 32'd0);
      chk("rd_req_run", 32'(rd_req), 32'(exp_req));
   endtask

   task automatic refill();
      auto_ret = 1'b0;
      repeat (10) begin
         credit_ret = 1'b1;
         tick();
      end
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; kload_ack = 1'b0; rd_ack = 1'b0; credit_ret = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_kload_req", 32'(kload_req), 32'd0);
      chk("rst_rd_req", 32'(rd_req), 32'd0);
      chk("rst_rd_row", 32'(rd_row), 32'd0);
      chk("rst_out_vld", 32'(out_vld), 32'd0);
      rst = 1'b0;
      run(2);

      // nominal frame with credits returned per result
      auto_ret = 1'b1; rd_ack = 1'b1; n_out = 0; n_iss = 0;
      kload_seq(1'b1);
      wait_done(200);
      chk("frame1_results", 32'(n_out), 32'(R * C));
      tick();
      chk("frame1_busy_low", 32'(busy), 32'd0);
`ifdef CONV_SCHED_PERF_EN
      chk("frame1_cycles", frame_cycles, 32'(n_busy));
`endif

      // credit starvation; extra returns while full must not raise the count above 8
      refill();
      n_iss = 0;
      kload_seq(1'b1);
      run(30);
      chk("stall_issues_8", 32'(n_iss), 32'd8);
      chk("stall_rd_req_low", 32'(rd_req), 32'd0);
      credit_ret = 1'b1;
      run(20);
      chk("stall_issues_9", 32'(n_iss), 32'd9);
      chk("stall_rd_req_low2", 32'(rd_req), 32'd0);
      rd_ack = 1'b0;
      repeat (3) begin
         credit_ret = 1'b1;
         tick();
      end
      chk("cred3_rd_req", 32'(rd_req), 32'd1);
      chk("cred3_rd_row", 32'(rd_row), 32'd2);
      chk("cred3_rd_col", 32'(rd_col), 32'd1);
      rd_ack = 1'b1; credit_ret = 1'b1;
      tick();
      run(20);
      chk("issue_ret_same_cycle", 32'(n_iss), 32'd13);
      chk("issue_ret_rd_req_low", 32'(rd_req), 32'd0);
      repeat (3) begin
         credit_ret = 1'b1;
         tick();
      end
      wait_done(100);
      chk("frame2_issues", 32'(n_iss), 32'(R * C));
      tick();

      // read backpressure at patch (1,2)
      refill();
      auto_ret = 1'b1; n_out = 0;
      kload_seq(1'b1);
      begin
         int k = 0;
         while (!(rd_req && rd_row == 8'd1 && rd_col == 8'd2) && k < 100) begin
            tick();
            k++;
         end
      end
      chk("bp_reached_row", 32'(rd_row), 32'd1);
      rd_ack = 1'b0;
      repeat (5) begin
         tick();
         chk("bp_row_hold", 32'(rd_row), 32'd1);
         chk("bp_col_hold", 32'(rd_col), 32'd2);
         chk("bp_req_hold", 32'(rd_req), 32'd1);
      end
      rd_ack = 1'b1;
      wait_done(200);
      chk("frame3_results", 32'(n_out), 32'(R * C));
`ifdef CONV_SCHED_PERF_EN
      chk("frame3_stall_cycles", stall_cycles, 32'd5);
`endif
      tick();

      // abort with three tokens in flight
      refill();
      auto_ret = 1'b1; n_iss = 0; n_done = 0;
      kload_seq(1'b1);
      begin
         int k = 0;
         while (n_iss < 3 && k < 50) begin
            tick();
            k++;
         end
      end
      chk("abort_inflight", 32'(n_iss), 32'd3);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy_low", 32'(busy), 32'd0);
      chk("abort_rd_req_low", 32'(rd_req), 32'd0);
      run(15);
      chk("abort_no_done", 32'(n_done), 32'd0);
      chk("abort_no_issue", 32'(n_iss), 32'd3);

      // full frame after abort restarts at (0,0)
      refill();
      auto_ret = 1'b1; n_out = 0;
      kload_seq(1'b1);
      wait_done(200);
      chk("frame5_results", 32'(n_out), 32'(R * C));
      tick();

      // asynchronous reset while draining
      refill();
      auto_ret = 1'b1; n_iss = 0;
      kload_seq(1'b1);
      begin
         int k = 0;
         while (n_iss < R * C && k < 100) begin
            tick();
            k++;
         end
      end
      run(2);
      chk("drain_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_out_vld", 32'(out_vld), 32'd0);
      chk("async_core_vld", 32'(core_vld), 32'd0);
      chk("async_rd_req", 32'(rd_req), 32'd0);
      chk("async_done", 32'(done), 32'd0);
`ifdef CONV_SCHED_PERF_EN
      chk("async_frame_cycles", frame_cycles, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      m_row = 0; m_col = 0; req_s = 1'b0;
      tick();
      chk("post_rst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
